// File: rtl/fpu_rcp_nr_pkg.sv
// Shared types and constants for the binary64 Newton-Raphson reciprocal refinement stage.
package fpu_rcp_nr_pkg;

    localparam int W      = 58;  // Q2.56 unsigned fixed point
    localparam int FRAC_W = 52;
    localparam int EXP_W  = 11;

    localparam logic [W-1:0]     ONE      = {2'b01, 56'h0};
    localparam logic [W-1:0]     TWO      = {2'b10, 56'h0};
    localparam logic [EXP_W-1:0] EXP_BIAS = 11'h3FF;
    localparam logic [EXP_W-1:0] EXP_MAX  = 11'h7FF;
    localparam logic [63:0]      POS_INF  = 64'h7FF0_0000_0000_0000;
    localparam int               QNAN_BIT = 51;

    typedef enum logic [2:0] {IDLE, MUL_T, MUL_X, PACK, DONE} state_t;

endpackage

// File: rtl/fpu_nr_mul58.sv
// 58x58 unsigned Q2.56 multiplier, one registered stage; the product is truncated back to Q2.56.
module fpu_nr_mul58
    import fpu_rcp_nr_pkg::*;
(
    input  logic         clock,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    logic [2*W-1:0] full;
    logic           unused_bits;

    assign full        = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign unused_bits = ^{full[2*W-1:2*W-2], full[W-3:0]};

    // NOTE: pure datapath register with no reset; the FSM never consumes it before it is written.
    always_ff @(posedge clock) begin
        p <= full[2*W-3:W-2];
    end

endmodule

// File: rtl/fpu_rcp_nr_refine.sv
// Newton-Raphson refinement of a ~12-bit reciprocal seed to a binary64 1/D on one shared multiplier.
// Optional: define FPU_RCP_NR_EXACTPOW2_EN to return exact powers of two without iterating.
module fpu_rcp_nr_refine
    import fpu_rcp_nr_pkg::*;
#(
    parameter int ITERS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [63:0] valRm,
    input  logic [63:0] valApx,
    output logic        outValid,
    input  logic        outReady,
    output logic [63:0] valRn
);

    localparam int                CW        = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0]     LAST_ITER = CW'(ITERS - 1);
    localparam logic signed [12:0] EXP_RCP  = 13'(2 * int'(EXP_BIAS));

    state_t              state_q, state_d;
    logic                phase_q;
    logic [CW-1:0]       iter_q;
    logic                sign_q, special_q;
    logic [EXP_W-1:0]    exp_q;
    logic [W-1:0]        d_q, x_q, t_q;
    logic [63:0]         res_q;

    logic                accept, in_sign, is_special;
    logic [EXP_W-1:0]    in_exp;
    logic [FRAC_W-1:0]   in_frac;
    logic [63:0]         special_res, pack_res;
    logic [W-1:0]        mul_a, mul_b, mul_p;
    logic                x_hi, rnd;
    logic [FRAC_W-1:0]   frac_raw;
    logic [FRAC_W:0]     frac_sum;
    logic signed [12:0]  exp_c;
    logic                unused_bits;

    assign in_sign     = valRm[63];
    assign in_exp      = valRm[62:FRAC_W];
    assign in_frac     = valRm[FRAC_W-1:0];
    assign inReady     = (state_q == IDLE);
    assign accept      = inValid && inReady;
    assign unused_bits = ^{valApx[63:FRAC_W], x_q[W-1], x_q[1:0], exp_c[12:EXP_W]};

    // Specials are resolved at accept time and skip the multiply states entirely.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        is_special  = 1'b1;
        special_res = '0;
        if (in_exp == '0) begin
            special_res = {in_sign, POS_INF[62:0]};
        end else if (in_exp == EXP_MAX && in_frac == '0) begin
            special_res = {in_sign, 63'h0};
        end else if (in_exp == EXP_MAX) begin
            special_res           = {in_sign, EXP_MAX, in_frac};
            special_res[QNAN_BIT] = 1'b1;
`ifdef FPU_RCP_NR_EXACTPOW2_EN
        end else if (in_frac == '0) begin
            special_res = (in_exp == EXP_RCP[EXP_W-1:0]) ? {in_sign, 63'h0}
                        : {in_sign, EXP_RCP[EXP_W-1:0] - in_exp, {FRAC_W{1'b0}}};
`endif
        end else begin
            is_special = 1'b0;
        end
    end

    always_comb begin
        mul_a = d_q;
        mul_b = x_q;
        if (state_q == MUL_X) begin
            mul_a = x_q;
            mul_b = TWO - t_q;  // wraps mod 2^58 when T > 2
        end
    end

    fpu_nr_mul58 u_mul (
        .clock (clock),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p)
    );

    // X is in (0.5, 1.0]; only the top bit decides which window feeds the fraction.
    always_comb begin
        x_hi     = x_q[W-2];
        frac_raw = x_hi ? x_q[W-3:4] : x_q[W-4:3];
        rnd      = x_hi ? x_q[3] : x_q[2];
        frac_sum = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, rnd};
        exp_c    = (x_hi ? EXP_RCP : EXP_RCP - 13'sd1) - $signed({2'b00, exp_q})
                 + $signed({12'b0, frac_sum[FRAC_W]});
        pack_res = {sign_q, 63'h0};
        if (exp_c > 13'sd0) begin
            pack_res = {sign_q, exp_c[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inValid) state_d = is_special ? PACK : MUL_T;
            MUL_T:   if (phase_q) state_d = MUL_X;
            MUL_X:   if (phase_q) state_d = (iter_q == LAST_ITER) ? PACK : MUL_T;
            PACK:    state_d = DONE;
            DONE:    if (outValid && outReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q  <= 1'b0;
            iter_q   <= '0;
            outValid <= 1'b0;
            valRn    <= '0;
        end else begin
            phase_q <= (state_q == MUL_T || state_q == MUL_X) && !phase_q;
            if (state_q == IDLE)             iter_q <= '0;
            else if (state_q == MUL_X && phase_q) iter_q <= iter_q + CW'(1);
            if (state_q == DONE && !outValid) begin
                outValid <= 1'b1;
                valRn    <= res_q;
            end else if (outValid && outReady) begin
                outValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            sign_q    <= in_sign;
            exp_q     <= in_exp;
            d_q       <= {2'b01, in_frac, 4'b0};
            x_q       <= (in_frac == '0) ? ONE : {3'b001, valApx[FRAC_W-1:0], 3'b000};
            special_q <= is_special;
            res_q     <= special_res;
        end
        if (state_q == MUL_T && phase_q) t_q <= mul_p;
        if (state_q == MUL_X && phase_q) x_q <= mul_p;
        if (state_q == PACK && !special_q) res_q <= pack_res;
    end

endmodule
